req_ack_responder: RTL



---
 rtl/req_ack_pkg.sv | 14 +
 rtl/ack_delay_line.sv | 56 +++++
 rtl/req_ack_responder.sv | 107 ++++++++++
 3 files changed

// File: rtl/req_ack_pkg.sv
// Shared types and limits for the request/acknowledge responder.
//   resp_state_e : responder state (IDLE, ACTIVE, ERROR)
//   MAX_LATENCY  : deepest supported request-to-ack delay
package req_ack_pkg;

    localparam int unsigned MAX_LATENCY = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        ERROR  = 2'd2
    } resp_state_e;

endpackage

// File: rtl/ack_delay_line.sv
// Fixed-latency token delay line with freeze and flush.
//   clk, rst : clock, asynchronous active-high reset
//   din      : token entering stage 0
//   flush    : zero every stage on the next edge
//   hold     : freeze all stages (ignored when flush is high)
//   dout     : token leaving the last stage (din itself when LATENCY=0)
//   any      : OR of all stages
//   any_nxt  : OR of the values the stages will take on the next edge
module ack_delay_line #(
    parameter int unsigned LATENCY = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic flush,
    input  logic hold,
    output logic dout,
    output logic any,
    output logic any_nxt
);

    if (LATENCY == 0) begin : g_bypass
        // Zero latency: the request is its own token, nothing is stored.
        logic unused_ok;
        assign unused_ok = &{1'b0, clk, rst, flush, hold};
        assign dout      = din;
        assign any       = 1'b0;
        assign any_nxt   = 1'b0;
    end else begin : g_shift
        logic [LATENCY-1:0] dly_q;
        logic [LATENCY-1:0] dly_d;

        // Next stage values; the cast drops the stage shifted out of the top.
        always_comb begin
            dly_d = dly_q;
            if (flush) begin
                dly_d = '0;
            end else if (!hold) begin
                dly_d = LATENCY'({dly_q, din});
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dly_q <= '0;
            end else begin
                dly_q <= dly_d;
            end
        end

        assign dout    = dly_q[LATENCY-1];
        assign any     = |dly_q;
        assign any_nxt = |dly_d;
    end

endmodule

// File: rtl/req_ack_responder.sv
// Turns each request pulse into exactly one acknowledge pulse after LATENCY
// cycles, buffering stalled acks in a pending counter and latching overflow.
//   clk, rst  : clock, asynchronous active-high reset
//   req       : request; every high cycle is one request
//   ack_stall : downstream stall, suppresses ack
//   clr_err   : leaves ERROR and flushes all state (no effect elsewhere)
//   ack       : acknowledge, combinational so LATENCY=0 acks in the req cycle
//   pending   : eligible acks not yet sent
//   busy      : pending acks or tokens still in the delay line
//   overflow  : high while in ERROR
module req_ack_responder
    import req_ack_pkg::*;
#(
    parameter int unsigned  LATENCY     = 0,
    parameter int unsigned  MAX_PENDING = 4,
    localparam int unsigned PEND_W      = $clog2(MAX_PENDING + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              ack_stall,
    input  logic              clr_err,
    output logic              ack,
    output logic [PEND_W-1:0] pending,
    output logic              busy,
    output logic              overflow
);

    // Out-of-range latencies are clamped to the deepest supported line.
    localparam int unsigned LAT = (LATENCY > MAX_LATENCY) ? MAX_LATENCY : LATENCY;

    resp_state_e       state_q, state_d;
    logic [PEND_W-1:0] pending_q, pending_d;

    logic in_err;
    logic req_eff;
    logic tok;
    logic line_any;
    logic line_any_nxt;
    logic line_hold;
    logic line_flush;
    logic ovf;

    assign in_err     = (state_q == ERROR);
    assign req_eff    = req && !in_err;
    assign line_hold  = in_err && !clr_err;
    assign line_flush = in_err && clr_err;

    ack_delay_line #(
        .LATENCY (LAT)
    ) u_dly (
        .clk     (clk),
        .rst     (rst),
        .din     (req_eff),
        .flush   (line_flush),
        .hold    (line_hold),
        .dout    (tok),
        .any     (line_any),
        .any_nxt (line_any_nxt)
    );

    // Next state, pending count and the combinational ack.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        ack       = 1'b0;
        ovf       = 1'b0;

        if (!in_err) begin
            ack = !rst && !ack_stall && ((pending_q != '0) || tok);
            // A token arriving with a full counter and no ack is dropped.
            ovf = (pending_q == PEND_W'(MAX_PENDING)) && tok && !ack;
        end

        unique case (state_q)
            ERROR: begin
                if (clr_err) begin
                    pending_d = '0;
                    state_d   = IDLE;
                end
            end
            default: begin
                if (ovf) begin
                    state_d = ERROR;
                end else begin
                    pending_d = pending_q + PEND_W'(tok) - PEND_W'(ack);
                    state_d   = ((pending_d != '0) || line_any_nxt) ? ACTIVE : IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

    assign pending  = pending_q;
    assign busy     = (pending_q != '0) || line_any;
    assign overflow = in_err;

endmodule
